alu_control_seq: RTL

Parametrised successor to the single-cycle ALU control decoder. It combines the {ALUOp, ALUFunction} decode with a small sequencer for multicycle MULT/DIV operations. While a multicycle operation runs, the sequencer stalls the pipeline with a cycle-exact handshake toward the mul/div datapath. It also flags illegal encodings and counts them. It sits between the main control unit and the ALU / mul-div unit in the MIPS datapath.

---
 rtl/alu_control_seq.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_control_seq.sv
// ALU control decoder with a MULT/DIV stall sequencer and a saturating
// illegal-instruction counter.
module alu_control_seq #(
  parameter int unsigned ALUOP_WIDTH     = 3,
  parameter int unsigned OPERATION_WIDTH = 4,
  parameter int unsigned MULT_CYCLES     = 32,
  parameter int unsigned DIV_CYCLES      = 32,
  parameter int unsigned ENABLE_MULDIV   = 1,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Valid,
  input  logic [ALUOP_WIDTH-1:0]     ALUOp,
  input  logic [5:0]                 ALUFunction,
  output logic [OPERATION_WIDTH-1:0] ALUOperation,
  output logic                       JumpRegister,
  output logic                       Illegal,
  output logic                       Stall,
  output logic                       MDStart,
  output logic                       MDDone,
  output logic                       Busy,
  output logic [CNT_WIDTH-1:0]       IllegalCount
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic       upper_ok_c;
  logic [3:0] op_code_c;
  logic       jr_c;
  logic       legal_c;
  logic       is_mult_c;
  logic       is_div_c;

  logic [0:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] illegal_cnt_q, illegal_cnt_d;
  logic                 stall_c, start_c, done_c, busy_c;

  // Extra ALUOp bits beyond the classic three must be zero.
  if (ALUOP_WIDTH > 3) begin : g_upper
    assign upper_ok_c = ~|ALUOp[ALUOP_WIDTH-1:3];
  end else begin : g_no_upper
    assign upper_ok_c = 1'b1;
  end

  // Combinational {ALUOp, funct} decode.
  always_comb begin
    op_code_c = 4'b1001;
    jr_c      = 1'b0;
    legal_c   = 1'b0;
    is_mult_c = 1'b0;
    is_div_c  = 1'b0;
    if (upper_ok_c) begin
      case (ALUOp[2:0])
        3'b111: begin
          case (ALUFunction)
            6'b100100: begin op_code_c = 4'b0000; legal_c = 1'b1; end
            6'b100101: begin op_code_c = 4'b0001; legal_c = 1'b1; end
            6'b100111: begin op_code_c = 4'b0010; legal_c = 1'b1; end
            6'b100000: begin op_code_c = 4'b0011; legal_c = 1'b1; end
            6'b100010: begin op_code_c = 4'b0100; legal_c = 1'b1; end
            6'b000000: begin op_code_c = 4'b0101; legal_c = 1'b1; end
            6'b000010: begin op_code_c = 4'b0110; legal_c = 1'b1; end
            6'b001000: begin op_code_c = 4'b0011; legal_c = 1'b1; jr_c = 1'b1; end
            6'b011000: begin
              if (ENABLE_MULDIV != 0) begin
                op_code_c = 4'b1010;
                legal_c   = 1'b1;
                is_mult_c = 1'b1;
              end
            end
            6'b011010: begin
              if (ENABLE_MULDIV != 0) begin
                op_code_c = 4'b1011;
                legal_c   = 1'b1;
                is_div_c  = 1'b1;
              end
            end
            default: ;
          endcase
        end
        3'b100:  begin op_code_c = 4'b0011; legal_c = 1'b1; end
        3'b101:  begin op_code_c = 4'b0001; legal_c = 1'b1; end
        3'b110:  begin op_code_c = 4'b0000; legal_c = 1'b1; end
        3'b011:  begin op_code_c = 4'b0111; legal_c = 1'b1; end
        3'b001:  begin op_code_c = 4'b0100; legal_c = 1'b1; end
        3'b000:  begin op_code_c = 4'b0011; legal_c = 1'b1; end
        default: ;
      endcase
    end
  end

  assign ALUOperation = OPERATION_WIDTH'(op_code_c);
  assign JumpRegister = jr_c;
  assign Illegal      = Valid & ~legal_c;

  // Sequencer next state and handshake outputs; handshake is held low in reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_c = 1'b0;
    start_c = 1'b0;
    done_c  = 1'b0;
    busy_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Valid && (is_mult_c || is_div_c)) begin
          stall_c = 1'b1;
          start_c = 1'b1;
          state_d = S_BUSY;
          cnt_d   = is_mult_c ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        end
      end
      S_BUSY: begin
        busy_c = 1'b1;
        if (cnt_q != '0) begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - CW'(1);
        end else begin
          done_c  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (!reset) begin
      stall_c = 1'b0;
      start_c = 1'b0;
      done_c  = 1'b0;
      busy_c  = 1'b0;
    end
  end

  assign Stall   = stall_c;
  assign MDStart = start_c;
  assign MDDone  = done_c;
  assign Busy    = busy_c;

  // Saturating count of illegal instructions accepted while not stalled.
  always_comb begin
    illegal_cnt_d = illegal_cnt_q;
    if (Illegal && !stall_c && (illegal_cnt_q != '1)) begin
      illegal_cnt_d = illegal_cnt_q + CNT_WIDTH'(1);
    end
  end

  assign IllegalCount = illegal_cnt_q;

  // State, cycle counter and illegal counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      illegal_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

endmodule
